frame_tx_gap: RTL

- Transmit-side framer for the serial link, the counterpart of the receive-side end-of-frame timeout detector.
- Takes frame bytes over a valid/ready interface with a last flag and issues them one at a time to the byte-level UART transmitter.
- Drives the line-driver enable with setup and hold margins.
- After each frame, enforces an idle gap long enough for the far-end receiver's timeout to fire, so frame boundaries are always detected.

---
 rtl/frame_tx_gap_if.sv | 21 ++
 rtl/frame_tx_gap.sv | 92 +++++++++
 2 files changed

// File: rtl/frame_tx_gap_if.sv
// Byte stream into the framer plus the framer-to-UART byte port.
// Pure wiring, no latency; tx_valid/tx_ready backpressure, uart_busy gates the next start.
interface frame_tx_gap_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] uart_data;
  logic       uart_start;
  logic       uart_busy;

  // master: byte source and UART side; slave: the framer
  modport master (
    output tx_data, tx_last, tx_valid, uart_busy,
    input  tx_ready, uart_data, uart_start
  );
  modport slave (
    input  tx_data, tx_last, tx_valid, uart_busy,
    output tx_ready, uart_data, uart_start
  );
endinterface

// File: rtl/frame_tx_gap.sv
// Transmit framer: issues bytes to the UART inside a de window, then idles 2^TOCNTSIZE-1 cycles.
// uart_start 1 cycle after acceptance; tx_ready only in READY with the UART idle; upstream stalls end in underrun.
module frame_tx_gap #(
  parameter int TOCNTSIZE  = 7,
  parameter int LEADCYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_tx_gap_if.slave bus,
  output logic          de,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);
  typedef enum logic [2:0] {IDLE, LEAD, READY, ISSUE, DRAIN, TAIL, GAP} state_t;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } cap_t;

  // The READY cycle is the last lead cycle and the busy-low DRAIN (or underrun) cycle
  // is the first hold cycle, so LEAD and TAIL each run LEADCYCLES-1 cycles themselves.
  localparam bit                   HAS_HOLD   = (LEADCYCLES > 1);
  localparam logic [TOCNTSIZE-1:0] HOLD_LAST  = TOCNTSIZE'(HAS_HOLD ? LEADCYCLES - 2 : 0);
  localparam logic [TOCNTSIZE-1:0] CNT_MAX    = '1;
  localparam state_t               AFTER_IDLE = HAS_HOLD ? LEAD : READY;
  localparam state_t               END_STATE  = HAS_HOLD ? TAIL : GAP;

  state_t               state_q, state_d;
  logic [TOCNTSIZE-1:0] cnt_q, cnt_d;
  cap_t                 cap_q, cap_d;
  logic                 de_q, de_d;
  logic                 start_q, start_d;
  logic                 rdy;
  logic                 hs;

  assign rdy = (state_q == READY) && !bus.uart_busy;
  assign hs  = rdy && bus.tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      de_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      de_q    <= de_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.tx_valid) state_d = AFTER_IDLE;
      LEAD:    if (cnt_q == HOLD_LAST) state_d = READY;
      READY: begin
        // A handshake on the terminal-count cycle takes priority over underrun.
        if (hs)                    state_d = ISSUE;
        else if (cnt_q == CNT_MAX) state_d = END_STATE;
      end
      ISSUE:   state_d = DRAIN;
      DRAIN:   if (!bus.uart_busy) state_d = cap_q.last ? END_STATE : READY;
      TAIL:    if (cnt_q == HOLD_LAST) state_d = GAP;
      GAP:     if (cnt_q == CNT_MAX) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Cleared on every state entry, so the shared counter never wraps.
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || (state_q inside {IDLE, ISSUE, DRAIN})) cnt_d = '0;

    cap_d   = hs ? cap_t'{last: bus.tx_last, data: bus.tx_data} : cap_q;
    de_d    = !(state_d inside {IDLE, GAP});
    start_d = (state_d == ISSUE);
  end

  always_comb begin
    bus.tx_ready = rdy;
    busy         = (state_q != IDLE);
    frame_done   = (state_q == GAP) && (cnt_q == CNT_MAX);
    underrun     = (state_q == READY) && (cnt_q == CNT_MAX) && !hs;
  end

  assign bus.uart_data  = cap_q.data;
  assign bus.uart_start = start_q;
  assign de             = de_q;
endmodule
